// File: rtl/ama_riscv_retire_trace.sv
// Retire trace buffer: queues retired-instruction records for a trace sink, keeps retirement stats, runs halt/drain FSM.
// Latency: a record accepted at edge N is visible on trace_valid/t_* in cycle N+1; no bypass; 1 record/cycle sustained.
// Backpressure: trace_ready low holds the head record; a record offered to a full FIFO with no pop is dropped and counted.

module ama_riscv_retire_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; caller only pushes when a slot is free or a pop frees one this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; data needs no reset since emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module ama_riscv_retire_trace #(
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int INST_WIDTH = 32,
    parameter int ARCH_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_retired,
    input  logic [INST_WIDTH-1:0] r_inst,
    input  logic [ARCH_WIDTH-1:0] r_pc,
    input  logic                  r_branch_inst,
    input  logic                  r_branch_taken,
    input  logic                  r_bp_hit,
    input  logic [ARCH_WIDTH-1:0] r_dmem_addr,
    input  logic [3:0]            r_dmem_size,
    input  logic                  halt_req,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [INST_WIDTH-1:0] t_inst,
    output logic [ARCH_WIDTH-1:0] t_pc,
    output logic                  t_branch_inst,
    output logic                  t_branch_taken,
    output logic                  t_bp_hit,
    output logic [ARCH_WIDTH-1:0] t_dmem_addr,
    output logic [3:0]            t_dmem_size,
    output logic [CNT_W-1:0]      cnt_ret,
    output logic [CNT_W-1:0]      cnt_br,
    output logic [CNT_W-1:0]      cnt_br_taken,
    output logic [CNT_W-1:0]      cnt_bp_hit,
    output logic [CNT_W-1:0]      cnt_ld,
    output logic [CNT_W-1:0]      cnt_st,
    output logic [CNT_W-1:0]      cnt_drop,
    output logic                  overflow,
    output logic                  done
);
    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ARCH_WIDTH-1:0] pc;
        logic                  branch_inst;
        logic                  branch_taken;
        logic                  bp_hit;
        logic [ARCH_WIDTH-1:0] dmem_addr;
        logic [3:0]            dmem_size;
    } rec_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state_q;
    state_t state_d;

    rec_t   rec_in;
    rec_t   rec_out;
    logic   fifo_full;
    logic   fifo_empty;
    logic   offer;
    logic   pop;
    logic   push;
    logic   drop;

    assign rec_in = '{inst: r_inst, pc: r_pc, branch_inst: r_branch_inst,
                      branch_taken: r_branch_taken, bp_hit: r_bp_hit,
                      dmem_addr: r_dmem_addr, dmem_size: r_dmem_size};

    // Only RUN accepts retirements; a same-cycle pop makes room in a full FIFO.
    assign offer = inst_retired && (state_q == RUN);
    assign pop   = trace_valid && trace_ready;
    assign push  = offer && (!fifo_full || pop);
    assign drop  = offer && fifo_full && !pop;

    ama_riscv_retire_trace_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (rec_in),
        .pop      (pop),
        .pop_dat  (rec_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign trace_valid    = !fifo_empty;
    assign t_inst         = rec_out.inst;
    assign t_pc           = rec_out.pc;
    assign t_branch_inst  = rec_out.branch_inst;
    assign t_branch_taken = rec_out.branch_taken;
    assign t_bp_hit       = rec_out.bp_hit;
    assign t_dmem_addr    = rec_out.dmem_addr;
    assign t_dmem_size    = rec_out.dmem_size;

    // Statistics count every offered record, dropped ones included.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ret      <= '0;
            cnt_br       <= '0;
            cnt_br_taken <= '0;
            cnt_bp_hit   <= '0;
            cnt_ld       <= '0;
            cnt_st       <= '0;
            cnt_drop     <= '0;
            overflow     <= 1'b0;
        end else if (offer) begin
            cnt_ret <= cnt_ret + CNT_ONE;
            if (r_branch_inst)                   cnt_br       <= cnt_br + CNT_ONE;
            if (r_branch_inst && r_branch_taken) cnt_br_taken <= cnt_br_taken + CNT_ONE;
            if (r_branch_inst && r_bp_hit)       cnt_bp_hit   <= cnt_bp_hit + CNT_ONE;
            if (r_dmem_size < 4'd4)              cnt_ld       <= cnt_ld + CNT_ONE;
            if (r_dmem_size[3:2] == 2'b01)       cnt_st       <= cnt_st + CNT_ONE;
            if (drop) begin
                cnt_drop <= cnt_drop + CNT_ONE;
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state: DRAIN finishes once the FIFO has been seen empty for a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_req)   state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    assign done = (state_q == DONE);
endmodule

// File: doc/ama_riscv_retire_trace.md
# ama_riscv_retire_trace

Verification-side trace buffer sitting directly downstream of the core view's retired-instruction record. Each cycle it captures the retired record (inst, pc, branch/taken/bp_hit, dmem addr/size), queues it in a FIFO, and drains it to a trace sink over a valid/ready handshake. It also keeps retirement statistics and runs a halt/drain state machine triggered by the tohost write, so the bench can end simulation only after every record has been consumed.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 2
- CNT_W, 32, width of each statistic counter; counters wrap
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- inst_retired  in  1  a record is valid this cycle
- r_inst  in  INST_WIDTH  retired instruction
- r_pc  in  ARCH_WIDTH  retired PC
- r_branch_inst  in  1  retired instruction is a branch
- r_branch_taken  in  1  branch resolved taken
- r_bp_hit  in  1  branch predictor hit
- r_dmem_addr  in  ARCH_WIDTH  data memory address
- r_dmem_size  in  4  access type: 0-3 lb/lh/lw/ld, 4-7 sb/sh/sw/sd, 8 no access
- halt_req  in  1  one-cycle pulse when tohost is written with a nonzero value
- trace_valid  out  1  head record available
- trace_ready  in  1  sink accepts the head record
- t_inst, t_pc, t_branch_inst, t_branch_taken, t_bp_hit, t_dmem_addr, t_dmem_size  out  same widths as the r_* inputs  head record fields
- cnt_ret, cnt_br, cnt_br_taken, cnt_bp_hit, cnt_ld, cnt_st, cnt_drop  out  CNT_W each  statistics
- overflow  out  1  sticky; set when any record is dropped
- done  out  1  drain finished; sticky until reset

## Operation
- Push: inst_retired and accept window open. A record is accepted only if the FIFO is not full, or a pop happens in the same cycle.
- Pop: trace_valid && trace_ready. The t_* outputs show the head entry. Contents are undefined while trace_valid = 0.
- Full, push, no pop: the record is dropped, cnt_drop increments, and overflow sets.
- Full, push, pop in the same cycle: the pop frees a slot and the push is accepted. Occupancy stays at DEPTH and nothing is dropped.
- Empty, push, trace_ready = 1: there is no bypass. The record pops the next cycle at the earliest.
- Counters count every record offered (inst_retired during the accept window), including dropped ones:
  - cnt_ret: every offered record
  - cnt_br: when r_branch_inst = 1
  - cnt_br_taken: when r_branch_inst && r_branch_taken
  - cnt_bp_hit: when r_branch_inst && r_bp_hit
  - cnt_ld: when r_dmem_size < 4
  - cnt_st: when 4 <= r_dmem_size <= 7
  - size 8 or above: no load/store count
- All counters wrap at 2^CNT_W; no saturation.
- FSM states RUN, DRAIN, DONE:
  - RUN: accept window open. halt_req moves it to DRAIN. A record retiring in the same cycle as halt_req is still accepted.
  - DRAIN: accept window closed. Retirements are ignored: not pushed, not counted. Popping continues. Moves to DONE in the cycle after the FIFO becomes empty; if already empty on entry, moves to DONE on the next cycle.
  - DONE: done = 1. Window closed. halt_req is ignored. Leaves DONE only on reset.
- halt_req in DRAIN or DONE has no effect.

## Timing
- Reset values (registered, 1 cycle):
  - FSM = RUN
  - FIFO empty, trace_valid = 0
  - all counters = 0
  - overflow = 0, done = 0
- Reset mid-operation discards all queued records and clears all state on the next edge. Inputs in the reset cycle are ignored.
- Push latency: a record accepted at edge N is visible on trace_valid/t_* after edge N (cycle N+1).
- Counters and overflow update at the edge that samples the record, so they are visible in cycle N+1.
- Sustained throughput: 1 record/cycle with trace_ready held high.
- trace_valid, once high, stays high with stable t_* until popped. Only rst breaks this rule.
- done rises one cycle after the last pop in DRAIN.
- Pointers are log2(DEPTH) bits wide, plus an extra wrap bit for full/empty detection.

## Test plan
- Single record: retire inst 0x00500093, pc 0x100, size 8, ready = 1.
  - Cycle +1: trace_valid = 1, t_pc = 0x100.
  - Cycle +2: trace_valid = 0.
  - cnt_ret = 1; cnt_ld = cnt_st = 0.
- Fill and overflow (DEPTH = 16, ready = 0): retire 18 consecutive records.
  - Occupancy 16, cnt_ret = 18, cnt_drop = 2, overflow = 1.
  - Drain order matches pc sequence 0x0, 0x4, … 0x3C.
- Full with simultaneous push/pop: at full, ready = 1 and retire for 5 cycles.
  - cnt_drop unchanged; occupancy stays 16; FIFO order preserved.
- Mixed stats over 8 records:
  - 3 branches (2 taken, 1 bp hit), 2 lw (size 2), 1 sb (size 4).
  - Expect cnt_br = 3, cnt_br_taken = 2, cnt_bp_hit = 1, cnt_ld = 2, cnt_st = 1.
- Halt/drain: 4 records queued, halt_req with a same-cycle retire, then 3 more retires, ready = 1.
  - Exactly 5 records pop; cnt_ret = 5.
  - done = 1 one cycle after the 5th pop, and stays high through another halt_req.
- Reset mid-drain: assert rst in DRAIN with 6 queued.
  - Next cycle: trace_valid = 0, counters = 0, done = 0, FSM = RUN; a new retire is accepted.
